// File: rtl/pool_ctrl_if.sv
// Stream and max_pool-side signals of pool_ctrl.
// The slave modport is the controller's view; master is the surrounding fabric.
interface pool_ctrl_if #(
  parameter int unsigned OPERAND_WDTH = 19
) ();

  logic                         in_vld_i;
  logic                         in_rdy_o;
  logic [OPERAND_WDTH-1:0]      in_pix_i;
  logic [1:0][OPERAND_WDTH-1:0] pool_a_o;
  logic [1:0][OPERAND_WDTH-1:0] pool_b_o;
  logic [OPERAND_WDTH-1:0]      max_pool_i;
  logic                         out_vld_o;
  logic                         out_rdy_i;
  logic [OPERAND_WDTH-1:0]      out_pix_o;
  logic                         out_last_o;

  modport slave (
    input  in_vld_i, in_pix_i, max_pool_i, out_rdy_i,
    output in_rdy_o, pool_a_o, pool_b_o, out_vld_o, out_pix_o, out_last_o
  );

  modport master (
    output in_vld_i, in_pix_i, max_pool_i, out_rdy_i,
    input  in_rdy_o, pool_a_o, pool_b_o, out_vld_o, out_pix_o, out_last_o
  );

endinterface

// File: rtl/pool_ctrl.sv
// Sequencing controller for the 2x2/stride-2 max_pool datapath.
// Buffers each even row, pairs it with the following odd row and launches one
// window per odd/odd position; the registered max_pool result is qualified with
// a valid/ready handshake. At most one window is in flight at a time.
module pool_ctrl #(
  parameter int unsigned OPERAND_WDTH = 19,
  parameter int unsigned IMG_WDTH     = 28,
  parameter int unsigned IMG_HGHT     = 28
) (
  input  logic           pool_clk,
  input  logic           pool_rst_b,
  pool_ctrl_if.slave     pool_if
);

  localparam int unsigned CW = $clog2(IMG_WDTH);
  localparam int unsigned RW = $clog2(IMG_HGHT);

  localparam logic [CW-1:0] ColEnd     = CW'(IMG_WDTH - 1);
  localparam logic [RW-1:0] RowEnd     = RW'(IMG_HGHT - 1);
  // Last odd column/row; with an odd dimension the trailing column/row is dropped.
  localparam logic [CW-1:0] ColLastOdd = CW'(IMG_WDTH - 1 - (IMG_WDTH % 2));
  localparam logic [RW-1:0] RowLastOdd = RW'(IMG_HGHT - 1 - (IMG_HGHT % 2));
  localparam logic [CW-1:0] ColLsb     = CW'(1);

  logic [CW-1:0]                r_col;
  logic [RW-1:0]                r_row;
  logic [OPERAND_WDTH-1:0]      r_line_buf [IMG_WDTH];
  logic [OPERAND_WDTH-1:0]      r_hold;
  logic [1:0][OPERAND_WDTH-1:0] r_pool_a;
  logic [1:0][OPERAND_WDTH-1:0] r_pool_b;
  logic                         r_win_vld;
  logic                         r_out_vld;
  logic                         r_last;

  logic          w_complete;
  logic          w_stall;
  logic          w_accept;
  logic          w_launch;
  logic [CW-1:0] w_col_left;

  // Odd row and odd column: this pixel closes a 2x2 window.
  assign w_complete = r_row[0] & r_col[0];
  // Only completing pixels wait, and only while the single window slot is busy.
  assign w_stall    = w_complete & (r_win_vld | (r_out_vld & ~pool_if.out_rdy_i));
  assign w_accept   = pool_if.in_vld_i & ~w_stall;
  assign w_launch   = w_accept & w_complete;
  // col is odd on launch, so clearing the LSB gives the left neighbour.
  assign w_col_left = r_col & ~ColLsb;

  assign pool_if.in_rdy_o   = ~w_stall;
  assign pool_if.pool_a_o   = r_pool_a;
  assign pool_if.pool_b_o   = r_pool_b;
  assign pool_if.out_vld_o  = r_out_vld;
  assign pool_if.out_pix_o  = pool_if.max_pool_i;
  assign pool_if.out_last_o = r_out_vld & r_last;

  // Raster position of the next pixel to accept; wraps straight into the next frame.
  always_ff @(posedge pool_clk or negedge pool_rst_b) begin
    if (!pool_rst_b) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == ColEnd) begin
        r_col <= '0;
        r_row <= (r_row == RowEnd) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Even rows fill the line buffer; odd rows park the even-column pixel in hold.
  always_ff @(posedge pool_clk or negedge pool_rst_b) begin
    if (!pool_rst_b) begin
      for (int i = 0; i < int'(IMG_WDTH); i++) begin
        r_line_buf[i] <= '0;
      end
      r_hold <= '0;
    end else if (w_accept) begin
      if (!r_row[0]) begin
        r_line_buf[r_col] <= pool_if.in_pix_i;
      end else if (!r_col[0]) begin
        r_hold <= pool_if.in_pix_i;
      end
    end
  end

  // Launch a completed window; operands hold until the next launch.
  always_ff @(posedge pool_clk or negedge pool_rst_b) begin
    if (!pool_rst_b) begin
      r_pool_a <= '0;
      r_pool_b <= '0;
      r_last   <= 1'b0;
    end else if (w_launch) begin
      r_pool_a <= {r_line_buf[r_col], r_line_buf[w_col_left]};
      r_pool_b <= {pool_if.in_pix_i, r_hold};
      r_last   <= (r_row == RowLastOdd) && (r_col == ColLastOdd);
    end
  end

  // Valid tracks max_pool's register stage, then waits for the output handshake.
  always_ff @(posedge pool_clk or negedge pool_rst_b) begin
    if (!pool_rst_b) begin
      r_win_vld <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      r_win_vld <= w_launch;
      if (r_win_vld) begin
        r_out_vld <= 1'b1;
      end else if (r_out_vld && pool_if.out_rdy_i) begin
        r_out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_ctrl.sv
// Bench for pool_ctrl: three instances (4x4, 5x5, 28x28) with a behavioural
// max_pool register, a reference model filling a per-instance scoreboard on
// every accepted completing pixel, and a monitor popping it on each handshake.
module tb_pool_ctrl;

  localparam int unsigned OW = 19;
  localparam int ExpOut [3]  = '{21, 8, 196};
  localparam int ExpLast [3] = '{5, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    rst_n;
  logic [2:0]    vld;
  logic [2:0]    ordy;
  logic [OW-1:0] pix [3];
  logic [2:0]    irdy;
  logic [2:0]    ovld;
  logic [2:0]    olast;
  logic [OW-1:0] opix [3];
  int            cnt_out [3];
  int            cnt_last [3];
  int            cnt_pend [3];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [OW-1:0] max4(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                        input logic [OW-1:0] c, input logic [OW-1:0] d);
    logic [OW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  for (genvar K = 0; K < 3; K++) begin : g_cfg
    localparam int unsigned W = (K == 0) ? 4 : (K == 1) ? 5 : 28;
    localparam int unsigned H = W;

    pool_ctrl_if #(.OPERAND_WDTH(OW)) bus ();
    logic [OW-1:0] mp_q;

    pool_ctrl #(
      .OPERAND_WDTH(OW),
      .IMG_WDTH    (W),
      .IMG_HGHT    (H)
    ) u_dut (
      .pool_clk  (clk),
      .pool_rst_b(rst_n[K]),
      .pool_if   (bus)
    );

    assign bus.in_vld_i   = vld[K];
    assign bus.in_pix_i   = pix[K];
    assign bus.out_rdy_i  = ordy[K];
    assign bus.max_pool_i = mp_q;
    assign irdy[K]        = bus.in_rdy_o;
    assign ovld[K]        = bus.out_vld_o;
    assign olast[K]       = bus.out_last_o;
    assign opix[K]        = bus.out_pix_o;

    // Behavioural max_pool: one register stage.
    always @(posedge clk) begin
      mp_q <= max4(bus.pool_a_o[0], bus.pool_a_o[1], bus.pool_b_o[0], bus.pool_b_o[1]);
    end

    logic [OW-1:0] rb [2][W];
    logic [OW:0]   sb [$];
    logic [OW:0]   e;
    logic [OW-1:0] e_pix;
    logic          e_last;
    logic          stall_q   = 1'b0;
    logic [OW-1:0] stall_pix = '0;
    int            m_col = 0, m_row = 0, n_out = 0, n_last = 0, n_pend = 0;

    assign cnt_out[K]  = n_out;
    assign cnt_last[K] = n_last;
    assign cnt_pend[K] = n_pend;

    // Inputs change on negedge; everything is sampled 1 time unit later.
    initial forever begin
      @(negedge clk);
      #1;
      if (!rst_n[K]) begin
        m_col   = 0;
        m_row   = 0;
        stall_q = 1'b0;
        sb.delete();
      end else begin
        if (stall_q) begin
          check_eq("hold_vld", 32'(ovld[K]), 1);
          check_eq("hold_pix", 32'(opix[K]), 32'(stall_pix));
        end
        if (!ovld[K]) check_eq("last_idle", 32'(olast[K]), 0);
        if (ovld[K] && ordy[K]) begin
          check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("out_pix", 32'(opix[K]), 32'(e[OW-1:0]));
            check_eq("out_last", 32'(olast[K]), 32'(e[OW]));
          end
          n_out++;
          n_last += int'(olast[K]);
        end
        stall_q   = ovld[K] && !ordy[K];
        stall_pix = opix[K];
        if (vld[K] && irdy[K]) begin
          if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
            e_pix  = max4(rb[0][m_col-1], rb[0][m_col], rb[1][m_col-1], pix[K]);
            e_last = (m_row == int'(H - 1 - (H % 2))) && (m_col == int'(W - 1 - (W % 2)));
            sb.push_back({e_last, e_pix});
          end
          rb[m_row % 2][m_col] = pix[K];
          if (m_col == int'(W) - 1) begin
            m_col = 0;
            m_row = (m_row == int'(H) - 1) ? 0 : m_row + 1;
          end else begin
            m_col++;
          end
        end
      end
      n_pend = sb.size();
    end
  end

  // Present one pixel and hold it until accepted; reports cycles spent stalled.
  task automatic send(input int k, input logic [OW-1:0] p, output int waited);
    waited = 0;
    @(negedge clk);
    vld[k] = 1'b1;
    pix[k] = p;
    #1;
    while (!irdy[k] && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!irdy[k]) check_eq("send_timeout", 32'(irdy[k]), 1);
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
  endtask

  task automatic stream(input int k, input int dim, input int frames, input bit rnd);
    int w;
    int drops = 0;
    ordy[k] = 1'b1;
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < dim * dim; i++) begin
        send(k, rnd ? OW'($urandom) : OW'(i), w);
        drops += w;
      end
    end
    check_eq("stream_rdy_drops", drops, 0);
  endtask

  task automatic scen4();
    int w;
    logic [OW-1:0] f [16];
    f = '{19'h7FFFF, 19'h7FFFF, 19'd3, 19'd3, 19'd0, 19'h7FFFF, 19'd3, 19'd3,
          19'h2AAAA, 19'h2AAAA, 19'h2AAAA, 19'h2AAAA,
          19'h2AAAA, 19'h2AAAA, 19'h2AAAA, 19'h2AAAA};

    // Raster 0..15 with latency probe around pixel 5.
    ordy[0] = 1'b1;
    for (int i = 0; i < 6; i++) send(0, OW'(i), w);
    @(negedge clk);
    #1;
    check_eq("lat_t1_vld", 32'(ovld[0]), 0);
    @(negedge clk);
    #1;
    check_eq("lat_t2_vld", 32'(ovld[0]), 1);
    check_eq("lat_t2_pix", 32'(opix[0]), 5);
    for (int i = 6; i < 16; i++) send(0, OW'(i), w);
    repeat (4) @(negedge clk);

    // Output stalled for 10 cycles right after the first result appears.
    for (int i = 0; i < 6; i++) begin
      send(0, OW'(i), w);
      check_eq("rdy_t2", w, 0);
    end
    @(negedge clk);
    @(negedge clk);
    ordy[0] = 1'b0;
    #1;
    check_eq("stall_vld", 32'(ovld[0]), 1);
    check_eq("stall_pix", 32'(opix[0]), 5);
    fork
      begin
        repeat (10) @(negedge clk);
        ordy[0] = 1'b1;
      end
      begin
        for (int i = 6; i < 16; i++) begin
          send(0, OW'(i), w);
          check_eq("rdy_t2_stalled", 32'(w != 0), 32'(i == 7));
        end
      end
    join
    repeat (4) @(negedge clk);

    // Reset with window 7 parked on a stalled output.
    for (int i = 0; i < 8; i++) send(0, OW'(i), w);
    ordy[0] = 1'b0;
    send(0, OW'(8), w);
    send(0, OW'(9), w);
    check_eq("pre_rst_vld", 32'(ovld[0]), 1);
    @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    check_eq("rst_mid_vld", 32'(ovld[0]), 0);
    check_eq("rst_mid_last", 32'(olast[0]), 0);
    check_eq("rst_mid_rdy", 32'(irdy[0]), 1);
    @(negedge clk);
    rst_n[0] = 1'b1;
    ordy[0]  = 1'b1;
    for (int i = 0; i < 16; i++) send(0, OW'(i), w);

    // Saturated and all-equal windows, two frames back-to-back.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) send(0, f[i], w);
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = '0;
    vld   = '0;
    ordy  = '0;
    for (int k = 0; k < 3; k++) pix[k] = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_vld", 32'(ovld[k]), 0);
      check_eq("rst_last", 32'(olast[k]), 0);
      check_eq("rst_rdy", 32'(irdy[k]), 1);
    end
    @(negedge clk);
    rst_n = '1;

    fork
      scen4();
      stream(1, 5, 2, 1'b0);
      stream(2, 28, 1, 1'b1);
    join

    repeat (10) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("n_out", cnt_out[k], ExpOut[k]);
      check_eq("n_last", cnt_last[k], ExpLast[k]);
      check_eq("sb_drained", cnt_pend[k], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
